// File: rtl/memory_arbiter_if.sv
// Cache/RAM handshake bundle between the icache, dcache, memory arbiter and RAM.
// The master modport is the arbiter's view; slave is the caches-plus-RAM side.
interface memory_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   modport master (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport slave (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates icache and dcache requests onto one RAM port. Dcache has priority,
// but a starvation counter forces an icache grant after STARVE_MAX dcache wins.
module memory_arbiter #(
   parameter int STARVE_MAX = 3
) (
   input  logic              CLK,
   input  logic              RST,
   memory_arbiter_if.master  bus
);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [1:0] RAM_ACCESS = 2'b10;
   localparam logic [1:0] RAM_ERROR  = 2'b11;

   typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  starve_reg, starve_next;
   logic        d_req, ram_done, ram_access;

   logic        iwait_c, dwait_c, ren_c, wen_c;
   logic [31:0] iload_c, dload_c, addr_c, store_c;

   assign d_req      = bus.dREN || bus.dWEN;
   assign ram_access = (bus.ramstate == RAM_ACCESS);
   assign ram_done   = ram_access || (bus.ramstate == RAM_ERROR);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg  <= IDLE;
         starve_reg <= '0;
      end else begin
         state_reg  <= state_next;
         starve_reg <= starve_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      starve_next = starve_reg;
      unique case (state_reg)
         IDLE: begin
            if (bus.iREN && starve_reg == STARVE_LIM) begin
               state_next  = ISERV;
               starve_next = '0;
            end else if (d_req) begin
               state_next = DSERV;
               // Only dcache wins that actually block a pending fetch count toward starvation.
               if (!bus.iREN)
                  starve_next = '0;
               else if (starve_reg != STARVE_LIM)
                  starve_next = starve_reg + 4'd1;
            end else if (bus.iREN) begin
               state_next  = ISERV;
               starve_next = '0;
            end
         end
         DSERV:   if (!d_req || ram_done) state_next = IDLE;
         ISERV:   if (!bus.iREN || ram_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      iwait_c = 1'b1;
      dwait_c = 1'b1;
      iload_c = '0;
      dload_c = '0;
      ren_c   = 1'b0;
      wen_c   = 1'b0;
      addr_c  = '0;
      store_c = '0;
      unique case (state_reg)
         DSERV: begin
            addr_c  = bus.daddr;
            store_c = bus.dstore;
            wen_c   = bus.dWEN;
            ren_c   = bus.dREN && !bus.dWEN;
            if (d_req && ram_access) begin
               dwait_c = 1'b0;
               dload_c = bus.dWEN ? 32'h0 : bus.ramload;
            end
         end
         ISERV: begin
            addr_c = bus.iaddr;
            ren_c  = bus.iREN;
            if (bus.iREN && ram_access) begin
               iwait_c = 1'b0;
               iload_c = bus.ramload;
            end
         end
         default: ;
      endcase
   end

   assign bus.iwait    = iwait_c;
   assign bus.iload    = iload_c;
   assign bus.dwait    = dwait_c;
   assign bus.dload    = dload_c;
   assign bus.ramREN   = ren_c;
   assign bus.ramWEN   = wen_c;
   assign bus.ramaddr  = addr_c;
   assign bus.ramstore = store_c;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small latency-programmable RAM model.
module tb_memory_arbiter;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   tests = 0;
   int   fails = 0;

   int   ram_lat   = 0;
   bit   force_err = 1'b0;
   int   ram_cnt   = 0;

   memory_arbiter_if bus ();

   memory_arbiter #(.STARVE_MAX(3)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // RAM: BUSY for ram_lat enabled cycles, then ACCESS (or ERROR when forced).
   always_comb begin
      if (!(bus.ramREN || bus.ramWEN)) bus.ramstate = 2'b00;
      else if (force_err)              bus.ramstate = 2'b11;
      else if (ram_cnt >= ram_lat)     bus.ramstate = 2'b10;
      else                             bus.ramstate = 2'b01;
   end

   always @(posedge CLK) begin
      if (bus.ramstate == 2'b01) ram_cnt <= ram_cnt + 1;
      else                       ram_cnt <= 0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " ramREN"}, 32'(bus.ramREN), 32'd0);
      chk({tag, " ramWEN"}, 32'(bus.ramWEN), 32'd0);
      chk({tag, " iwait"},  32'(bus.iwait),  32'd1);
      chk({tag, " dwait"},  32'(bus.dwait),  32'd1);
   endtask

   initial begin
      bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
      bus.daddr = 0; bus.dstore = 0; bus.ramload = 32'hDEADBEEF;

      // Reset state
      #2;
      chk_idle("rst");
      chk("rst iload", bus.iload, 32'h0);
      chk("rst dload", bus.dload, 32'h0);
      tick();
      RST = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_idle($sformatf("idle%0d", i));
      end
      $display("[TB] reset/idle done");

      // dcache read, RAM ACCESS two cycles after enable
      ram_lat = 2;
      bus.dREN = 1; bus.daddr = 32'h40;
      settle();
      chk("rd idle ramREN", 32'(bus.ramREN), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rd c%0d ramREN", i), 32'(bus.ramREN), 32'd1);
         chk($sformatf("rd c%0d ramaddr", i), bus.ramaddr, 32'h40);
         chk($sformatf("rd c%0d dwait", i), 32'(bus.dwait), (i == 2) ? 32'd0 : 32'd1);
         chk($sformatf("rd c%0d iwait", i), 32'(bus.iwait), 32'd1);
      end
      chk("rd dload", bus.dload, 32'hDEADBEEF);
      tick();
      bus.dREN = 0;
      settle();
      chk_idle("rd after");
      $display("[TB] dcache read 0x40 -> 0xDEADBEEF");

      // Simultaneous icache read and dcache write: dcache first
      ram_lat = 0;
      bus.iREN = 1; bus.iaddr = 32'h0;
      bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
      bus.ramload = 32'h0BADF00D;
      tick();
      chk("sim d ramWEN",   32'(bus.ramWEN), 32'd1);
      chk("sim d ramREN",   32'(bus.ramREN), 32'd0);
      chk("sim d ramstore", bus.ramstore, 32'h1234);
      chk("sim d ramaddr",  bus.ramaddr, 32'h80);
      chk("sim d dwait",    32'(bus.dwait), 32'd0);
      chk("sim d dload",    bus.dload, 32'h0);
      chk("sim d iwait",    32'(bus.iwait), 32'd1);
      tick();
      bus.dWEN = 0;
      settle();
      chk_idle("sim gap");
      tick();
      chk("sim i ramREN",  32'(bus.ramREN), 32'd1);
      chk("sim i ramaddr", bus.ramaddr, 32'h0);
      chk("sim i iwait",   32'(bus.iwait), 32'd0);
      chk("sim i iload",   bus.iload, 32'h0BADF00D);
      chk("sim i dwait",   32'(bus.dwait), 32'd1);
      tick();
      bus.iREN = 0;
      settle();
      chk_idle("sim after");
      $display("[TB] simultaneous i/d: d served then i");

      // Starvation: expect D,D,D,I,D,D,D,I
      bus.dREN = 1; bus.daddr = 32'h100;
      bus.iREN = 1; bus.iaddr = 32'h200;
      for (int g = 0; g < 8; g++) begin
         bit is_i;
         is_i = (g % 4) == 3;
         tick();
         chk($sformatf("stv g%0d ramaddr", g), bus.ramaddr, is_i ? 32'h200 : 32'h100);
         chk($sformatf("stv g%0d iwait", g), 32'(bus.iwait), is_i ? 32'd0 : 32'd1);
         chk($sformatf("stv g%0d dwait", g), 32'(bus.dwait), is_i ? 32'd1 : 32'd0);
         $display("[TB] starve grant %0d: %s", g, is_i ? "I" : "D");
         tick();
         if (g == 7) begin
            bus.dREN = 0; bus.iREN = 0;
            settle();
         end
         chk_idle($sformatf("stv gap%0d", g));
      end

      // ERROR on dcache read: no response, retried after IDLE
      bus.dREN = 1; bus.daddr = 32'h44; bus.ramload = 32'hCAFEF00D;
      force_err = 1;
      tick();
      chk("err ramREN", 32'(bus.ramREN), 32'd1);
      chk("err dwait",  32'(bus.dwait), 32'd1);
      chk("err dload",  bus.dload, 32'h0);
      tick();
      force_err = 0;
      settle();
      chk_idle("err gap");
      tick();
      chk("err retry ramaddr", bus.ramaddr, 32'h44);
      chk("err retry dwait",   32'(bus.dwait), 32'd0);
      chk("err retry dload",   bus.dload, 32'hCAFEF00D);
      tick();
      bus.dREN = 0;
      settle();
      chk_idle("err after");
      $display("[TB] ERROR retried and completed");

      // Reset pulse while DSERV waits on a slow RAM
      ram_lat = 5;
      bus.dREN = 1; bus.daddr = 32'h48;
      tick();
      chk("rstmid ramREN busy", 32'(bus.ramREN), 32'd1);
      chk("rstmid dwait busy",  32'(bus.dwait), 32'd1);
      RST = 1'b1;
      settle();
      chk_idle("rstmid async");
      bus.dREN = 0;
      tick();
      chk_idle("rstmid held");
      RST = 1'b0;
      tick();
      chk_idle("rstmid released");
      ram_lat = 0;
      bus.dREN = 1; bus.daddr = 32'h4C; bus.ramload = 32'h55AA55AA;
      tick();
      chk("rstmid new ramaddr", bus.ramaddr, 32'h4C);
      chk("rstmid new dwait",   32'(bus.dwait), 32'd0);
      chk("rstmid new dload",   bus.dload, 32'h55AA55AA);
      tick();
      bus.dREN = 0;
      settle();
      chk_idle("rstmid after");
      $display("[TB] reset mid-access aborted, new request served");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Arbitrates the instruction cache and data cache request ports onto the single-ported RAM and returns per-cache wait/load responses. It sits directly downstream of the data cache (and icache), consuming their cache-control request signals and driving the RAM interface. Grants are registered and held until the RAM completes or faults. Data-cache requests have priority, bounded by a starvation limit that guarantees instruction-fetch progress.

## Interface
- STARVE_MAX, 3: consecutive dcache grants allowed while iREN is pending before icache is forced a grant (1..15).
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low for exactly the cycle iload is valid.
- iload  out  32  instruction word.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request (wins over dREN if both high).
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  low for exactly the cycle the dcache access completes.
- dload  out  32  data word for reads.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  00 FREE, 01 BUSY, 10 ACCESS (op done), 11 ERROR.

## Operation
- States: IDLE, DSERV, ISERV. Reset: IDLE, starve counter 0.
- IDLE: no RAM enables; iwait=dwait=1; loads 0. Next state:
  - iREN && starve==STARVE_MAX -> ISERV.
  - else (dREN||dWEN) -> DSERV.
  - else iREN -> ISERV; else stay.
- Starve counter (4 bit, saturating at STARVE_MAX): on IDLE->DSERV, increments if iREN high, else clears to 0; on IDLE->ISERV, clears to 0.
- DSERV: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&&!dWEN.
  - ramstate ACCESS: dwait=0 this cycle, dload=ramload (reads; 0 for writes), -> IDLE.
  - ramstate ERROR: dwait stays 1, -> IDLE (request re-arbitrated, i.e. retried).
  - dREN and dWEN both low (request withdrawn): RAM enables 0, -> IDLE, no response.
  - FREE/BUSY: hold, dwait=1.
- ISERV: identical with ramaddr=iaddr, ramREN=iREN, ramWEN=0, response on iwait/iload, withdrawal on iREN low.
- Non-granted cache always sees wait=1 and load=0.
- RAM outputs (addr, store) are 0 in IDLE and are combinational from the granted cache's inputs while serving.
- dcache two-word block fills/writebacks are two independent grants; an icache grant may interleave between them.

## Timing
- Request visible in cycle N (IDLE) -> RAM enables asserted in N+1. Zero-latency RAM (ACCESS in N+1) -> wait low in N+1. Minimum 2 cycles per access, 1 IDLE cycle between consecutive grants.
- Wait low lasts exactly one cycle per completed access; the requester may drop or change its request in the following cycle.
- Grant never switches mid-access; a newly arriving dcache request during ISERV waits for completion.
- Simultaneous iREN and dREN/dWEN in IDLE with starve<STARVE_MAX -> dcache wins.
- RST asserted mid-access: immediately IDLE, all RAM enables 0, both waits 1, counter 0; the in-flight access produces no response.
- ramstate ERROR never lowers a wait.

## Test plan
- Reset: RST high -> ramREN=ramWEN=0, iwait=dwait=1, iload=dload=0; release, idle 5 cycles, outputs unchanged.
- dcache read daddr=0x40, RAM ACCESS 2 cycles after enable with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 for 3 cycles, dwait low one cycle with dload=0xDEADBEEF, iwait stays 1.
- Simultaneous iREN (iaddr=0x0) and dWEN (daddr=0x80, dstore=0x1234) -> dcache served first (ramWEN=1, ramstore=0x1234), then icache after one IDLE cycle.
- Starvation, STARVE_MAX=3: dREN and iREN held continuously, zero-latency RAM -> grant sequence D,D,D,I,D,D,D,I.
- ERROR: RAM returns ERROR on a dcache read -> dwait stays 1, arbiter re-grants dcache after IDLE; next ACCESS completes with dwait low once.
- RST pulse while DSERV awaits ACCESS -> next cycle IDLE, ramREN=0, no dwait low for the aborted access; new request then served normally.
